// File: rtl/lo_seq_ctrl_if.sv
// Configuration handshake for the LO sequencing controller.
// The master offers a tuning word and burst length; the slave accepts on valid & ready.
`timescale 1ns/1ps
interface lo_seq_ctrl_if #(
  parameter int ACC_W = 8,
  parameter int LEN_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_ftw;
  logic [LEN_W-1:0] cfg_len;

  modport master (output cfg_valid, cfg_ftw, cfg_len, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ftw, cfg_len, output cfg_ready);
endinterface

// File: rtl/lo_seq_ctrl.sv
// Sequencing controller for the 16-entry sine LO: phase accumulator, burst control,
// and retune deferral so a new tuning word only takes effect at a phase wrap.
`timescale 1ns/1ps
module lo_seq_ctrl #(
  parameter int ACC_W = 8,
  parameter int LEN_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  lo_seq_ctrl_if.slave cfg,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         lo_valid,
  output logic [7:0]   lo_out,
  output logic [3:0]   lo_addr,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ACC_W-1:0] FTW_RST = ACC_W'(1) << (ACC_W - 4);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, ftw, pend_ftw;
  logic [LEN_W-1:0] len, blen, cnt, pend_len;
  logic             pending;
  logic             go, step, fin;
  logic             accept, wrap;
  logic [ACC_W:0]   sum;
  logic [3:0]       addr;

  function automatic logic [7:0] sin_lut(input logic [3:0] a);
    case (a)
      4'd0:  sin_lut = 8'd100;
      4'd1:  sin_lut = 8'd138;
      4'd2:  sin_lut = 8'd171;
      4'd3:  sin_lut = 8'd192;
      4'd4:  sin_lut = 8'd200;
      4'd5:  sin_lut = 8'd192;
      4'd6:  sin_lut = 8'd171;
      4'd7:  sin_lut = 8'd138;
      4'd8:  sin_lut = 8'd100;
      4'd9:  sin_lut = 8'd62;
      4'd10: sin_lut = 8'd29;
      4'd11: sin_lut = 8'd8;
      4'd12: sin_lut = 8'd0;
      4'd13: sin_lut = 8'd8;
      4'd14: sin_lut = 8'd29;
      default: sin_lut = 8'd62;
    endcase
  endfunction

  assign cfg.cfg_ready = !pending;
  assign accept        = cfg.cfg_valid && !pending;
  assign sum           = {1'b0, acc} + {1'b0, ftw};
  assign wrap          = step && sum[ACC_W];
  assign addr          = acc[ACC_W-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = RUN;
          go       = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (blen != '0 && cnt == blen - 1'b1) begin
            fin      = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sample generation and burst bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      blen     <= '0;
      busy     <= 1'b0;
      lo_valid <= 1'b0;
      lo_out   <= 8'd100;
      lo_addr  <= 4'd0;
      done     <= 1'b0;
    end else begin
      done     <= fin;
      lo_valid <= step;
      busy     <= (state_nx == RUN);
      if (go) begin
        acc  <= '0;
        cnt  <= '0;
        blen <= accept ? cfg.cfg_len : len;
      end else if (step) begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt + 1'b1;
      end
      if (step) begin
        lo_out  <= sin_lut(addr);
        lo_addr <= addr;
      end
    end
  end

  // Config loads immediately outside a burst; mid-burst it waits for a phase wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw      <= FTW_RST;
      len      <= '0;
      pend_ftw <= '0;
      pend_len <= '0;
      pending  <= 1'b0;
    end else if (state == IDLE || state_nx == IDLE) begin
      if (accept) begin
        ftw <= cfg.cfg_ftw;
        len <= cfg.cfg_len;
      end else if (pending) begin
        ftw <= pend_ftw;
        len <= pend_len;
      end
      pending <= 1'b0;
    end else if (wrap && pending) begin
      ftw     <= pend_ftw;
      len     <= pend_len;
      pending <= 1'b0;
    end else if (accept) begin
      pend_ftw <= cfg.cfg_ftw;
      pend_len <= cfg.cfg_len;
      pending  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lo_seq_ctrl.sv
// Scoreboard bench for lo_seq_ctrl: stimulus queues expected samples, a negedge
// monitor pops and compares them whenever lo_valid is high.
`timescale 1ns/1ps
module tb_lo_seq_ctrl;

  typedef struct {
    logic [7:0] out;
    logic [3:0] addr;
    logic       dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy, lo_valid, done;
  logic [7:0] lo_out;
  logic [3:0] lo_addr;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [7:0] sin_tab [16] = '{8'd100, 8'd138, 8'd171, 8'd192, 8'd200, 8'd192, 8'd171, 8'd138,
                               8'd100, 8'd62, 8'd29, 8'd8, 8'd0, 8'd8, 8'd29, 8'd62};

  lo_seq_ctrl_if #(.ACC_W(8), .LEN_W(8)) cfg_if ();

  lo_seq_ctrl #(.ACC_W(8), .LEN_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .lo_valid (lo_valid),
    .lo_out   (lo_out),
    .lo_addr  (lo_addr),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] o, input logic [3:0] a, input logic d);
    exp_t e;
    e.out = o; e.addr = a; e.dn = d;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [7:0] f, input logic [7:0] l);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ftw   = f;
    cfg_if.cfg_len   = l;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  // Monitor: every presented sample must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (lo_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_sample", {24'd0, lo_out}, 32'd999);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("lo_out", {24'd0, lo_out}, {24'd0, e.out});
          check("lo_addr", {28'd0, lo_addr}, {28'd0, e.addr});
          check("done_with_sample", {31'd0, done}, {31'd0, e.dn});
        end
      end else begin
        check("done_without_sample", {31'd0, done}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ftw   = '0;
    cfg_if.cfg_len   = '0;

    // Reset state
    tick(2);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_lo_valid", {31'd0, lo_valid}, 0);
    check("rst_lo_out", {24'd0, lo_out}, 100);
    check("rst_lo_addr", {28'd0, lo_addr}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_cfg_ready", {31'd0, cfg_if.cfg_ready}, 1);
    rst_n = 1'b1;
    tick(1);

    // Continuous burst with reset defaults (ftw=16, len=0)
    for (int i = 0; i < 20; i++) push(sin_tab[i % 16], 4'(i % 16), 1'b0);
    pulse_start();
    check("t1_busy_after_start", {31'd0, busy}, 1);
    check("t1_no_sample_yet", {31'd0, lo_valid}, 0);
    tick(20);
    pulse_stop();
    check("t1_stop_valid", {31'd0, lo_valid}, 0);
    check("t1_stop_busy", {31'd0, busy}, 0);
    check("t1_drained", sb.size(), 0);

    // Finite burst, ftw=32 len=4
    cfg_write(8'd32, 8'd4);
    push(8'd100, 4'd0, 1'b0);
    push(8'd171, 4'd2, 1'b0);
    push(8'd200, 4'd4, 1'b0);
    push(8'd171, 4'd6, 1'b1);
    pulse_start();
    tick(4);
    tick(1);
    check("t2_busy_after", {31'd0, busy}, 0);
    check("t2_valid_after", {31'd0, lo_valid}, 0);
    check("t2_drained", sb.size(), 0);

    // Retune mid-burst applies only at the wrap
    cfg_write(8'd16, 8'd0);
    for (int i = 0; i < 16; i++) push(sin_tab[i], 4'(i), 1'b0);
    for (int i = 0; i < 8; i++) push(sin_tab[2 * i], 4'(2 * i), 1'b0);
    pulse_start();
    tick(4);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ftw   = 8'd32;
    cfg_if.cfg_len   = 8'd0;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    check("t3_ready_low", {31'd0, cfg_if.cfg_ready}, 0);
    tick(10);
    check("t3_ready_low_prewrap", {31'd0, cfg_if.cfg_ready}, 0);
    tick(1);
    check("t3_ready_back", {31'd0, cfg_if.cfg_ready}, 1);
    tick(8);
    pulse_stop();
    check("t3_drained", sb.size(), 0);

    // Stop mid-burst, len=10
    cfg_write(8'd16, 8'd10);
    push(8'd100, 4'd0, 1'b0);
    push(8'd138, 4'd1, 1'b0);
    push(8'd171, 4'd2, 1'b0);
    pulse_start();
    tick(3);
    pulse_stop();
    check("t4_valid", {31'd0, lo_valid}, 0);
    check("t4_done", {31'd0, done}, 0);
    check("t4_busy", {31'd0, busy}, 0);
    check("t4_hold_out", {24'd0, lo_out}, 171);
    check("t4_hold_addr", {28'd0, lo_addr}, 2);
    tick(2);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_busy", {31'd0, busy}, 0);
    tick(1);
    check("t5_valid", {31'd0, lo_valid}, 0);

    // Asynchronous reset mid-burst with a config pending
    cfg_write(8'd16, 8'd0);
    push(8'd100, 4'd0, 1'b0);
    push(8'd138, 4'd1, 1'b0);
    push(8'd171, 4'd2, 1'b0);
    pulse_start();
    tick(2);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ftw   = 8'd48;
    cfg_if.cfg_len   = 8'd5;
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    check("t6_pending", {31'd0, cfg_if.cfg_ready}, 0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_valid", {31'd0, lo_valid}, 0);
    check("t6_out", {24'd0, lo_out}, 100);
    check("t6_ready", {31'd0, cfg_if.cfg_ready}, 1);
    check("t6_done", {31'd0, done}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) push(sin_tab[i], 4'(i), 1'b0);
    pulse_start();
    tick(4);
    pulse_stop();
    check("t6_drained", sb.size(), 0);

    // len=1: single sample with done
    cfg_write(8'd16, 8'd1);
    push(8'd100, 4'd0, 1'b1);
    pulse_start();
    tick(1);
    tick(1);
    check("t7_busy", {31'd0, busy}, 0);
    check("t7_valid", {31'd0, lo_valid}, 0);

    // ftw=0, len=3
    cfg_write(8'd0, 8'd3);
    push(8'd100, 4'd0, 1'b0);
    push(8'd100, 4'd0, 1'b0);
    push(8'd100, 4'd0, 1'b1);
    pulse_start();
    tick(3);
    tick(1);
    check("t8_busy", {31'd0, busy}, 0);

    // start during RUN is ignored
    cfg_write(8'd16, 8'd6);
    for (int i = 0; i < 5; i++) push(sin_tab[i], 4'(i), 1'b0);
    push(sin_tab[5], 4'd5, 1'b1);
    pulse_start();
    tick(2);
    pulse_start();
    tick(3);
    tick(1);
    check("t9_busy", {31'd0, busy}, 0);

    tick(3);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lo_seq_ctrl.md
# lo_seq_ctrl

Sequencing controller for the 16-entry, 8-bit sine local oscillator used in the VLSI datapath. It owns the phase accumulator that addresses the sine table and the registered LO output. It accepts frequency and burst-length configuration over a valid/ready handshake, and runs continuous or fixed-length bursts on start/stop commands. A retune requested mid-burst is applied only at a phase wrap, so the waveform never jumps in phase.

## Interface
- ACC_W, 8, phase accumulator width (≥5); table address = acc[ACC_W-1:ACC_W-4]
- LEN_W, 8, burst length counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- cfg_ftw  in  ACC_W  frequency tuning word (phase step per sample)
- cfg_len  in  LEN_W  burst length in samples; 0 = continuous
- start  in  1  begin burst (honoured in IDLE only)
- stop  in  1  abort burst
- busy  out  1  registered, 1 while in RUN
- lo_valid  out  1  lo_out holds a new sample this cycle
- lo_out  out  8  sine sample
- lo_addr  out  4  table address of the current lo_out
- done  out  1  one-cycle pulse, coincident with the last sample of a finite burst

## Operation
- Sine table (fixed): 100,138,171,192,200,192,171,138,100,62,29,8,0,8,29,62.
- Reset values: state IDLE, acc=0, ftw=1<<(ACC_W-4) (one table step per sample), len=0, no pending config, cnt=0. Outputs: busy=0, lo_valid=0, lo_out=100, lo_addr=0, done=0, cfg_ready=1.
- cfg_ready = !pending.
- Config accepted in IDLE: ftw and len load at that edge.
- Config accepted in RUN: cfg_ftw and cfg_len go into pending registers. cfg_ready drops the next cycle.
- FSM has two states.
- IDLE → RUN on start & !stop. At that edge acc←0, cnt←0, busy←1. If start and stop are both high, stop wins and the block stays idle.
- RUN, each cycle without stop:
  - lo_out←sin[acc top 4 bits], lo_addr←same address, lo_valid←1.
  - acc←(acc+ftw) mod 2^ACC_W.
  - cnt←cnt+1.
- Wrap: the carry out of acc+ftw. On a wrap edge with a config pending, ftw←pending ftw, len←pending len, and pending clears. The sum on that edge uses the old ftw. The new len affects only later bursts; the active burst keeps its latched length.
- Finite burst: if len≠0 and cnt==len-1, the sample emitted at that edge is the last. done←1, busy←0, state←IDLE.
- stop in RUN: next edge state←IDLE, lo_valid←0, busy←0, no done, no sample emitted. lo_out keeps its last value.
- start while in RUN is ignored.
- Entering IDLE with a config pending applies it at that same edge; cfg_ready returns to 1 the following cycle.
- ftw=0 is legal: lo_out holds sin[0] for the whole burst, and a pending config never applies until the burst ends.

## Timing
- start sampled at edge N. busy=1 after N; the first sample (sin[0]=100, lo_valid=1) appears after edge N+1. From then on, one sample per clock.
- done and the last lo_valid are high in the same cycle. The next cycle has lo_valid=0, busy=0, done=0.
- cfg handshake completes in the cycle cfg_valid & cfg_ready is high at the clock edge.
- A config accepted on the same edge as a wrap goes into pending and waits for the next wrap.
- rst_n low at any time: all registers and outputs take their reset values immediately (asynchronously), pending config is discarded, and no done is emitted. The first edge after rst_n rises is treated as IDLE.

## Test plan
- Reset, then start with defaults (ftw=16, len=0): lo_out=100,138,171,192,200,192,171,138,100,62,29,8,0,8,29,62,100,… with lo_valid held at 1 and done never asserted.
- In IDLE, configure ftw=32, len=4, then start: samples 100,171,200,171. done=1 with the 4th sample; busy and lo_valid are 0 the next cycle.
- Continuous run at ftw=16; at the 5th sample configure ftw=32:
  - cfg_ready=0 from the next cycle.
  - Steps of 1 continue through 62 (wrap edge).
  - Output then continues 100,171,200,171,…
  - cfg_ready returns to 1 after the wrap.
- stop mid-burst, and the start/stop edge cases:
  - stop mid-burst with len=10 after 3 samples: lo_valid=0 next cycle, done stays 0, lo_out holds 171.
  - start and stop together in IDLE: busy stays 0.
- rst_n pulsed low mid-burst with a config pending: outputs go immediately to busy=0, lo_valid=0, lo_out=100, cfg_ready=1. A new start produces step-1 output (ftw=16).
- Edge cases:
  - len=1: single sample 100 with done.
  - ftw=0, len=3: 100,100,100 then done.
  - start asserted during RUN: no restart.
